digit_scan_driver: RTL and testbench

DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

---
 rtl/clock_disp_defs.sv | 20 ++
 rtl/seg7_decode.sv | 23 ++
 rtl/digit_scan_driver.sv | 110 +++++++++++
 tb/tb_digit_scan_driver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clock_disp_defs.sv
// clock_disp_defs: shared display types and constants (scan FSM states, active-low
// seven-segment patterns, all-off output values).
package clock_disp_defs;
    localparam int CNT_W = 20;
    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_LIT} scan_state_e;
    localparam logic [6:0] SEG_0       = 7'h40;
    localparam logic [6:0] SEG_1       = 7'h79;
    localparam logic [6:0] SEG_2       = 7'h24;
    localparam logic [6:0] SEG_3       = 7'h30;
    localparam logic [6:0] SEG_4       = 7'h19;
    localparam logic [6:0] SEG_5       = 7'h12;
    localparam logic [6:0] SEG_6       = 7'h02;
    localparam logic [6:0] SEG_7       = 7'h78;
    localparam logic [6:0] SEG_8       = 7'h00;
    localparam logic [6:0] SEG_9       = 7'h10;
    localparam logic [6:0] SEG_DASH    = 7'h3F;
    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;
    localparam logic [3:0] AN_ALL_OFF  = 4'hF;
    localparam logic       DP_OFF      = 1'b1;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit value to active-low {g,f,e,d,c,b,a}; 0-9 as digits, A-F as a dash.
module seg7_decode
    import clock_disp_defs::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);
    always_comb begin
        case (hex_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: 4-digit multiplexed seven-segment scanner with per-slot dead time,
// blanking/blink/leading-zero masking and registered active-low drive.
module digit_scan_driver
    import clock_disp_defs::*;
#(
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [1:0] sel_out,
    input  logic [3:0] digit_in,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_mask,
    input  logic [3:0] blink_mask,
    input  logic       blink_phase,
    input  logic       lzb,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_tick
);
    if (DEAD_CYCLES < 1 || SLOT_CYCLES < DEAD_CYCLES + 1 || SLOT_CYCLES > 2 ** CNT_W) begin : g_bad_params
        $error("digit_scan_driver: illegal SLOT_CYCLES/DEAD_CYCLES");
    end

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIT_LAST  = CNT_W'(SLOT_CYCLES - DEAD_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d, seg_dec;
    logic             dp_q, dp_d, tick_q, tick_d;
    logic             dark, on;

    seg7_decode u_dec (.hex_i(digit_in), .seg_n_o(seg_dec));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        sel_d   = sel_q;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                    sel_d   = '0;
                end
                ST_DEAD: if (cnt_q == DEAD_LAST) begin
                    state_d = ST_LIT;
                    cnt_d   = '0;
                end
                ST_LIT: if (cnt_q == LIT_LAST) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                    tick_d  = (sel_q == 2'd3);
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // Output stage looks at the pre-edge state, giving the 1-cycle drive latency.
    always_comb begin
        dark = blank_mask[sel_q] | (blink_mask[sel_q] & blink_phase) | (lzb && sel_q == 2'd3 && digit_in == 4'd0);
        on   = en && state_q == ST_LIT && !dark;
        an_d  = on ? (AN_ALL_OFF & ~(4'b0001 << sel_q)) : AN_ALL_OFF;
        seg_d = on ? seg_dec : SEG_ALL_OFF;
        dp_d  = on ? ~dp_in[sel_q] : DP_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            sel_q   <= '0;
            an_q    <= AN_ALL_OFF;
            seg_q   <= SEG_ALL_OFF;
            dp_q    <= DP_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign sel_out    = sel_q;
    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver: timeline reference model feeds a scoreboard queue; a monitor
// compares every cycle's registered outputs against it.
module tb_digit_scan_driver;
    localparam int SLOT = 8;
    localparam int DEAD = 2;
    localparam int FRAME = 4 * SLOT;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic [1:0] sel;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, blink_phase = 1'b0, lzb = 1'b0;
    logic [1:0] sel_out;
    logic [3:0] digit_in, dp_in = '0, blank_mask = '0, blink_mask = '0, an_n;
    logic [6:0] seg_n;
    logic dp_n, frame_tick;
    logic [3:0] digits [4];
    logic [6:0] seg_tab [16];
    exp_t q[$];
    int t = -1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign digit_in = digits[sel_out];

    digit_scan_driver #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_out(sel_out), .digit_in(digit_in),
        .dp_in(dp_in), .blank_mask(blank_mask), .blink_mask(blink_mask),
        .blink_phase(blink_phase), .lzb(lzb), .an_n(an_n), .seg_n(seg_n),
        .dp_n(dp_n), .frame_tick(frame_tick)
    );

    // t counts cycles since the scan left OFF; slot and phase follow by division.
    always @(negedge rst_n) t = -1;

    always @(posedge clk) begin
        exp_t e;
        int ph, sl;
        logic [3:0] d;
        logic dk;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, sel: 2'd0};
        if (rst_n && en) begin
            if (t >= 0) begin
                ph = t % SLOT;
                sl = (t / SLOT) % 4;
                d  = digits[sl];
                dk = blank_mask[sl] | (blink_mask[sl] & blink_phase) | (lzb && sl == 3 && d == 4'd0);
                if (ph >= DEAD && !dk) begin
                    e.an  = 4'hF & ~(4'b0001 << sl);
                    e.seg = seg_tab[d];
                    e.dp  = ~dp_in[sl];
                end
            end
            e.sel  = 2'(((t + 1) / SLOT) % 4);
            e.tick = (t >= 0) && ((t + 1) % FRAME == 0);
            t = (t + 1) % FRAME;
        end else begin
            t = -1;
        end
        q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = q.pop_front();
            if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp || frame_tick !== e.tick || sel_out !== e.sel) begin
                errors++;
                $display("FAIL outputs at %0t: got an=%h seg=%h dp=%b tick=%b sel=%0d, want an=%h seg=%h dp=%b tick=%b sel=%0d",
                         $time, an_n, seg_n, dp_n, frame_tick, sel_out, e.an, e.seg, e.dp, e.tick, e.sel);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d);
        digits[0] = a; digits[1] = b; digits[2] = c; digits[3] = d;
    endtask

    initial begin
        bit found;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        en = 1'b1;
        cycles(3 * FRAME);
        lzb = 1'b1;
        digits[3] = 4'd0;
        cycles(2 * FRAME);
        digits[3] = 4'd5;
        cycles(FRAME);
        lzb = 1'b0;
        blink_mask = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            cycles(SLOT);
            blink_phase = ~blink_phase;
        end
        blink_mask = '0;
        blink_phase = 1'b0;
        set_digits(4'd7, 4'hC, 4'd9, 4'hF);
        dp_in = 4'b0010;
        cycles(2 * FRAME);
        dp_in = '0;
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            found = (sel_out == 2'd2 && an_n != 4'hF);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_digit2_lit: never saw digit 2 lit");
        end
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(FRAME);
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            found = (an_n != 4'hF);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_lit_before_reset: never saw a lit anode");
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0 || sel_out !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got an=%h seg=%h dp=%b tick=%b sel=%0d, want an=f seg=7f dp=1 tick=0 sel=0",
                     an_n, seg_n, dp_n, frame_tick, sel_out);
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(FRAME);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) digits[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) blink_phase = ~blink_phase;
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lzb = ~lzb;
        end
        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
